// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter: round-robin time-slot arbiter sharing one 4-digit display between four requesters
// Optional SSD_ARB_PRIORITY_EN makes source 0 preempt other owners.
module ssd_display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] vals,
  input  logic [15:0] masks,
  output logic [3:0]  grant,
  output logic [1:0]  src,
  output logic        busy,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  mode
);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [1:0] ptr, win, own;
  logic found, load;
  assign busy = (state == SHOW);
  always_comb begin
    found = |req;
    win = ptr;
    for (int k = 4; k >= 1; k--) if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    nstate = state;
    ncnt = cnt;
    load = 1'b0;
    if (state == IDLE) begin
      nstate = found ? SHOW : IDLE;
      load = found;
    end else if (!req[src] || cnt == '0) begin
      nstate = found ? SHOW : IDLE;
      load = found;
    end else ncnt = cnt - 1'b1;
`ifdef SSD_ARB_PRIORITY_EN
    if (state == SHOW && req[0] && src != 2'd0) begin
      win = 2'd0;
      load = 1'b1;
      nstate = SHOW;
    end
`endif
    if (load) ncnt = CNT_W'(HOLD_CYCLES - 1);
    own = load ? win : src;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= 2'd3;
      src <= 2'd0;
      grant <= 4'd0;
      mode <= 4'd0;
      {digit3, digit2, digit1, digit0} <= 16'd0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      if (load) begin
        ptr <= win;
        src <= win;
      end
      grant <= (nstate == SHOW) ? 4'b1 << own : 4'd0;
      mode <= (nstate == SHOW) ? masks[4*own +: 4] : 4'd0;
      if (nstate == SHOW) {digit3, digit2, digit1, digit0} <= vals[16*own +: 16];
    end
  end
endmodule

// File: tb/tb_ssd_display_arbiter.sv
// tb_ssd_display_arbiter: randomized bench against a slot-level reference model of the arbiter
module tb_ssd_display_arbiter;
  localparam int H = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [63:0] vals = '0;
  logic [15:0] masks = '0;
  logic [3:0] grant, digit0, digit1, digit2, digit3, mode;
  logic [1:0] src;
  logic busy;
  int n_tests = 0, n_fail = 0;
  int m_owner, m_left, m_ptr;
  logic [15:0] m_dig;
  logic [3:0] m_mode;

  ssd_display_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .vals(vals), .masks(masks),
    .grant(grant), .src(src), .busy(busy),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(logic [3:0] r, int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset;
    m_owner = -1; m_left = 0; m_ptr = 3; m_dig = '0; m_mode = '0;
  endtask

  task automatic model_grant(int w);
    m_owner = w; m_left = H; m_ptr = w;
  endtask

  // One slot-level step: m_left counts cycles still owed to the current owner.
  task automatic model_step;
    int w;
    if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) model_grant(w);
    end
`ifdef SSD_ARB_PRIORITY_EN
    else if (req[0] && m_owner != 0) model_grant(0);
`endif
    else if (!req[m_owner] || m_left == 1) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) model_grant(w); else m_owner = -1;
    end else m_left--;
    if (m_owner >= 0) begin
      m_dig = vals[16*m_owner +: 16];
      m_mode = masks[4*m_owner +: 4];
    end else m_mode = '0;
  endtask

  task automatic tick;
    logic [3:0] eg;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    eg = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    n_tests++;
    if (grant !== eg || busy !== (m_owner >= 0)) begin
      n_fail++;
      $display("FAIL tick_grant t=%0t grant=%b busy=%b expected grant=%b busy=%b", $time, grant, busy, eg, m_owner >= 0);
    end
    n_tests++;
    if (mode !== m_mode || {digit3, digit2, digit1, digit0} !== m_dig) begin
      n_fail++;
      $display("FAIL tick_display t=%0t mode=%b digits=%h expected mode=%b digits=%h", $time, mode, {digit3, digit2, digit1, digit0}, m_mode, m_dig);
    end
    if (m_owner >= 0) begin
      n_tests++;
      if (src !== 2'(m_owner)) begin
        n_fail++;
        $display("FAIL tick_src t=%0t src=%0d expected %0d", $time, src, m_owner);
      end
    end
    n_tests++;
    if ($countones(grant) > 1) begin
      n_fail++;
      $display("FAIL tick_onehot t=%0t grant=%b expected one-hot or zero", $time, grant);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    vals = {$urandom, $urandom};
    masks = 16'hffff;
    req = 4'hf;
    tick(); tick();
    n_tests++;
    if (grant !== 4'd0 || busy !== 1'b0 || src !== 2'd0 || mode !== 4'd0 || {digit3, digit2, digit1, digit0} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state grant=%b busy=%b src=%0d mode=%b digits=%h expected all zero", grant, busy, src, mode, {digit3, digit2, digit1, digit0});
    end
    req = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    vals = {48'h0, 16'h1234};
    masks = 16'h000f;
    req = 4'b0001;
    tick();
    n_tests++;
    if (grant !== 4'b0001 || busy !== 1'b1 || {digit3, digit2, digit1, digit0} !== 16'h1234 || mode !== 4'hf) begin
      n_fail++;
      $display("FAIL single_first grant=%b busy=%b digits=%h mode=%b expected 0001 1 1234 1111", grant, busy, {digit3, digit2, digit1, digit0}, mode);
    end
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_alternate;
    int zeros = 0, changes = 0;
    logic [3:0] last;
    vals = {$urandom, $urandom};
    masks = $urandom;
    req = 4'b0101;
    last = grant;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant == 4'd0) zeros++;
      if (grant != last) changes++;
      last = grant;
    end
    n_tests++;
    if (zeros != 0 || changes != 5) begin
      n_fail++;
      $display("FAIL alternate zero_cycles=%0d changes=%0d expected 0 and 5", zeros, changes);
    end
  endtask

  task automatic test_release;
    tick(); tick();
    req = 4'd0;
    tick();
    n_tests++;
    if (grant !== 4'd0 || busy !== 1'b0 || mode !== 4'd0) begin
      n_fail++;
      $display("FAIL release grant=%b busy=%b mode=%b expected 0000 0 0000", grant, busy, mode);
    end
    tick();
  endtask

  task automatic test_wrap;
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] seen [5];
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 33; i++) begin
      tick();
      if (i % 8 == 0) seen[i / 8] = grant;
    end
    for (int j = 0; j < 5; j++) begin
      n_tests++;
      if (seen[j] !== exp_seq[j]) begin
        n_fail++;
        $display("FAIL wrap_slot%0d grant=%b expected %b", j, seen[j], exp_seq[j]);
      end
    end
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    req = 4'b0010;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (grant !== 4'd0 || busy !== 1'b0 || src !== 2'd0 || mode !== 4'd0 || {digit3, digit2, digit1, digit0} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid grant=%b busy=%b src=%0d mode=%b digits=%h expected all zero", grant, busy, src, mode, {digit3, digit2, digit1, digit0});
    end
    model_reset();
    tick(); tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    n_tests++;
    if (grant !== 4'b1000 || src !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_restart grant=%b src=%0d expected 1000 3", grant, src);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_preempt;
    logic [3:0] eg;
`ifdef SSD_ARB_PRIORITY_EN
    eg = 4'b0001;
`else
    eg = 4'b0100;
`endif
    pulse_reset();
    vals = {$urandom, $urandom};
    masks = $urandom;
    req = 4'b0100;
    tick(); tick();
    req = 4'b0101;
    tick();
    n_tests++;
    if (grant !== eg) begin
      n_fail++;
      $display("FAIL preempt grant=%b expected %b", grant, eg);
    end
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_random;
    pulse_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(5) == 0) req = 4'($urandom);
      vals = {$urandom, $urandom};
      if ($urandom_range(3) == 0) masks = 16'($urandom);
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_release();
    test_wrap();
    test_reset_mid();
    test_preempt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
